// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multicycle initiator for an 8x8 register file.
// Accepts one instruction at a time over valid/ready, issues the register
// file read phase (CTRL=1), computes the result in a small ALU and issues a
// single write-back cycle (CTRL=0). DONE pulses once per retired instruction.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic              CTRL,
  output logic [ADDR_W-1:0] OUT1ADDR,
  output logic [ADDR_W-1:0] OUT2ADDR,
  output logic [ADDR_W-1:0] INADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic              DONE,
  output logic              ILLEGAL
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] out1addr_reg, out1addr_next;
  logic [ADDR_W-1:0] out2addr_reg, out2addr_next;
  logic              done_reg, done_next;
  logic              illegal_reg, illegal_next;
  logic [DATA_W-1:0] alu_result;

  // Field views of the latched instruction. Only the low ADDR_W bits of each
  // address field matter; the source fields go straight into the address
  // registers at handshake, so their latched copies are never read.
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0] imm_val;
  logic              unused_fields;

  assign opcode        = instr_reg[31:24];
  assign dest_addr     = instr_reg[16 +: ADDR_W];
  assign imm_val       = DATA_W'(instr_reg[7:0]);
  assign unused_fields = ^{instr_reg[23:16+ADDR_W], instr_reg[15:8]};

  // State and latched-instruction registers; reset forces IDLE at once so
  // CTRL returns high without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      instr_reg    <= '0;
      out1addr_reg <= '0;
      out2addr_reg <= '0;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      instr_reg    <= instr_next;
      out1addr_reg <= out1addr_next;
      out2addr_reg <= out2addr_next;
      done_reg     <= done_next;
      illegal_reg  <= illegal_next;
    end
  end

  // Next-state decode: handshake only in IDLE, opcode picks the path.
  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    out1addr_next = out1addr_reg;
    out2addr_next = out2addr_reg;
    done_next     = 1'b0;
    illegal_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          instr_next = INSTR;
          case (INSTR[31:24])
            OP_LOADI: begin
              state_next = ST_WRITE;
            end
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              // Addresses are registered here so they are stable for the
              // whole READ cycle and hold afterwards.
              state_next    = ST_READ;
              out1addr_next = INSTR[8 +: ADDR_W];
              out2addr_next = INSTR[0 +: ADDR_W];
            end
            default: begin
              // Unknown opcode: retire immediately without touching the file.
              done_next    = 1'b1;
              illegal_next = 1'b1;
            end
          endcase
        end
      end
      ST_READ: begin
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ALU: results wrap modulo 2^DATA_W; operands arrive on RD1/RD2 during WRITE.
  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_LOADI: alu_result = imm_val;
      OP_MOV:   alu_result = RD2;
      OP_ADD:   alu_result = RD1 + RD2;
      OP_SUB:   alu_result = RD1 - RD2;
      OP_AND:   alu_result = RD1 & RD2;
      OP_OR:    alu_result = RD1 | RD2;
      default:  alu_result = '0;
    endcase
  end

  assign INSTR_READY = (state_reg == ST_IDLE);
  assign CTRL        = (state_reg != ST_WRITE);
  assign OUT1ADDR    = out1addr_reg;
  assign OUT2ADDR    = out2addr_reg;
  assign INADDR      = dest_addr;
  // WDATA is only meaningful in the write cycle; keep it quiet elsewhere.
  assign WDATA       = (state_reg == ST_WRITE) ? alu_result : '0;
  assign DONE        = done_reg;
  assign ILLEGAL     = illegal_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed testbench for regfile_sequencer with a behavioural 8x8 register
// file: reads sampled on posedge while CTRL=1, writes on negedge while CTRL=0.
module tb_regfile_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  RD1, RD2;
  logic        CTRL;
  logic [2:0]  OUT1ADDR, OUT2ADDR, INADDR;
  logic [7:0]  WDATA;
  logic        DONE, ILLEGAL;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] rd1_q = 8'h00;
  logic [7:0] rd2_q = 8'h00;

  assign RD1 = rd1_q;
  assign RD2 = rd2_q;

  regfile_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .RD1(RD1), .RD2(RD2), .CTRL(CTRL),
    .OUT1ADDR(OUT1ADDR), .OUT2ADDR(OUT2ADDR), .INADDR(INADDR),
    .WDATA(WDATA), .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Register file model
  always @(posedge CLK) begin
    if (CTRL) begin
      rd1_q <= rf[OUT1ADDR];
      rd2_q <= rf[OUT2ADDR];
    end
  end

  always @(negedge CLK) begin
    if (!CTRL) rf[INADDR] <= WDATA;
  end

  // Event counters sampled mid-cycle
  always @(negedge CLK) begin
    if (!CTRL) wr_cnt++;
    if (DONE) done_cnt++;
    if (INSTR_VALID && INSTR_READY && !RESET) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents an instruction and returns 1ns after the accepting edge.
  task automatic issue(input logic [31:0] instr, input bit hold);
    int waited = 0;
    INSTR = instr;
    INSTR_VALID = 1'b1;
    while (!INSTR_READY && waited < 20) begin
      tick();
      waited++;
    end
    if (!INSTR_READY) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: READY=%0b after %0d cycles, required 1", INSTR_READY, waited);
    end
    tick();
    if (!hold) INSTR_VALID = 1'b0;
  endtask

  task automatic load(input logic [2:0] r, input logic [7:0] v);
    issue({8'h00, 5'b0, r, 8'h00, v}, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; INSTR = 32'h0; INSTR_VALID = 1'b0;
    #2;
    n_checks++; if (CTRL !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl: got %0b required 1", CTRL); end
    n_checks++; if (INSTR_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", INSTR_READY); end
    n_checks++; if (DONE !== 1'b0 || ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: DONE=%0b ILLEGAL=%0b required 0/0", DONE, ILLEGAL); end
    n_checks++; if ({OUT1ADDR, OUT2ADDR, INADDR} !== 9'h0) begin n_fail++; $display("FAIL reset_addr: got %h/%h/%h required 0/0/0", OUT1ADDR, OUT2ADDR, INADDR); end
    n_checks++; if (WDATA !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h required 00", WDATA); end
    tick(); tick();
    RESET = 1'b0;
    tick();
    n_checks++; if (CTRL !== 1'b1 || INSTR_READY !== 1'b1) begin n_fail++; $display("FAIL reset_release: CTRL=%0b READY=%0b required 1/1", CTRL, INSTR_READY); end
  endtask

  task automatic test_loadi();
    int w0 = wr_cnt;
    issue(32'h0002005A, 1'b0);
    n_checks++; if (CTRL !== 1'b0) begin n_fail++; $display("FAIL loadi_ctrl_write: got %0b required 0", CTRL); end
    n_checks++; if (INADDR !== 3'd2) begin n_fail++; $display("FAIL loadi_inaddr: got %0d required 2", INADDR); end
    n_checks++; if (WDATA !== 8'h5A) begin n_fail++; $display("FAIL loadi_wdata: got %h required 5a", WDATA); end
    n_checks++; if (DONE !== 1'b0 || INSTR_READY !== 1'b0) begin n_fail++; $display("FAIL loadi_busy: DONE=%0b READY=%0b required 0/0", DONE, INSTR_READY); end
    tick();
    n_checks++; if (DONE !== 1'b1 || ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL loadi_done: DONE=%0b ILLEGAL=%0b required 1/0", DONE, ILLEGAL); end
    n_checks++; if (CTRL !== 1'b1) begin n_fail++; $display("FAIL loadi_ctrl_after: got %0b required 1", CTRL); end
    tick();
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL loadi_done_pulse: got %0b required 0", DONE); end
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL loadi_write_count: got %0d required 1", wr_cnt - w0); end
    n_checks++; if (rf[2] !== 8'h5A) begin n_fail++; $display("FAIL loadi_reg: r2=%h required 5a", rf[2]); end
  endtask

  task automatic test_add();
    load(3'd1, 8'hF0);
    load(3'd3, 8'h20);
    issue(32'h02040103, 1'b0);
    n_checks++; if (OUT1ADDR !== 3'd1 || OUT2ADDR !== 3'd3) begin n_fail++; $display("FAIL add_read_addr: got %0d/%0d required 1/3", OUT1ADDR, OUT2ADDR); end
    n_checks++; if (CTRL !== 1'b1 || INSTR_READY !== 1'b0) begin n_fail++; $display("FAIL add_read_phase: CTRL=%0b READY=%0b required 1/0", CTRL, INSTR_READY); end
    tick();
    n_checks++; if (CTRL !== 1'b0 || INADDR !== 3'd4) begin n_fail++; $display("FAIL add_write_phase: CTRL=%0b INADDR=%0d required 0/4", CTRL, INADDR); end
    n_checks++; if (WDATA !== 8'h10) begin n_fail++; $display("FAIL add_wdata: got %h required 10", WDATA); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL add_done_early: got %0b required 0", DONE); end
    tick();
    n_checks++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL add_done: got %0b required 1", DONE); end
    n_checks++; if (rf[4] !== 8'h10) begin n_fail++; $display("FAIL add_reg: r4=%h required 10", rf[4]); end
    tick();
  endtask

  task automatic test_alu_ops();
    logic [31:0] ops [4]  = '{32'h03000103, 32'h04050103, 32'h05060103, 32'h01070003};
    logic [7:0]  exps [4] = '{8'hFE, 8'h30, 8'hFC, 8'h3C};
    logic [2:0]  dsts [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
    load(3'd1, 8'h05);
    load(3'd3, 8'h07);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        load(3'd1, 8'hF0);
        load(3'd3, 8'h3C);
      end
      issue(ops[i], 1'b0);
      tick();
      n_checks++; if (WDATA !== exps[i] || INADDR !== dsts[i] || CTRL !== 1'b0) begin n_fail++; $display("FAIL alu_op%0d: WDATA=%h INADDR=%0d CTRL=%0b required %h/%0d/0", i, WDATA, INADDR, CTRL, exps[i], dsts[i]); end
      tick();
      n_checks++; if (DONE !== 1'b1 || rf[dsts[i]] !== exps[i]) begin n_fail++; $display("FAIL alu_op%0d_retire: DONE=%0b reg=%h required 1/%h", i, DONE, rf[dsts[i]], exps[i]); end
    end
    tick();
  endtask

  task automatic test_illegal();
    int w0 = wr_cnt;
    issue(32'h09010203, 1'b0);
    n_checks++; if (DONE !== 1'b1 || ILLEGAL !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: DONE=%0b ILLEGAL=%0b required 1/1", DONE, ILLEGAL); end
    n_checks++; if (INSTR_READY !== 1'b1 || CTRL !== 1'b1) begin n_fail++; $display("FAIL illegal_idle: READY=%0b CTRL=%0b required 1/1", INSTR_READY, CTRL); end
    tick();
    n_checks++; if (DONE !== 1'b0 || ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_end: DONE=%0b ILLEGAL=%0b required 0/0", DONE, ILLEGAL); end
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL illegal_no_write: got %0d writes required 0", wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int a0 = acc_cnt;
    issue(32'h00020011, 1'b1);
    n_checks++; if (INSTR_READY !== 1'b0) begin n_fail++; $display("FAIL b2b_busy0: READY=%0b required 0", INSTR_READY); end
    issue(32'h02050202, 1'b1);
    n_checks++; if (INSTR_READY !== 1'b0 || OUT1ADDR !== 3'd2 || OUT2ADDR !== 3'd2) begin n_fail++; $display("FAIL b2b_busy1: READY=%0b addr=%0d/%0d required 0/2/2", INSTR_READY, OUT1ADDR, OUT2ADDR); end
    issue(32'h03050502, 1'b0);
    n_checks++; if (INSTR_READY !== 1'b0 || CTRL !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2: READY=%0b CTRL=%0b required 0/1", INSTR_READY, CTRL); end
    tick();
    n_checks++; if (WDATA !== 8'h11 || INADDR !== 3'd5) begin n_fail++; $display("FAIL b2b_sub_wdata: WDATA=%h INADDR=%0d required 11/5", WDATA, INADDR); end
    tick();
    n_checks++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL b2b_last_done: got %0b required 1", DONE); end
    tick();
    n_checks++; if (acc_cnt - a0 !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", acc_cnt - a0); end
    n_checks++; if (done_cnt - d0 !== 3) begin n_fail++; $display("FAIL b2b_dones: got %0d required 3", done_cnt - d0); end
    n_checks++; if (wr_cnt - w0 !== 3) begin n_fail++; $display("FAIL b2b_writes: got %0d required 3", wr_cnt - w0); end
    n_checks++; if (rf[5] !== 8'h11 || rf[2] !== 8'h11) begin n_fail++; $display("FAIL b2b_regs: r5=%h r2=%h required 11/11", rf[5], rf[2]); end
  endtask

  task automatic test_reset_in_write();
    int w0;
    int d0;
    issue(32'h000300AA, 1'b0);
    n_checks++; if (CTRL !== 1'b0) begin n_fail++; $display("FAIL rstw_in_write: CTRL=%0b required 0", CTRL); end
    w0 = wr_cnt;
    d0 = done_cnt;
    RESET = 1'b1;
    #1;
    n_checks++; if (CTRL !== 1'b1 || INSTR_READY !== 1'b1) begin n_fail++; $display("FAIL rstw_async: CTRL=%0b READY=%0b required 1/1", CTRL, INSTR_READY); end
    @(negedge CLK);
    #1;
    n_checks++; if (rf[3] !== 8'h3C) begin n_fail++; $display("FAIL rstw_reg_kept: r3=%h required 3c", rf[3]); end
    tick();
    RESET = 1'b0;
    tick();
    n_checks++; if (INSTR_READY !== 1'b1 || CTRL !== 1'b1 || DONE !== 1'b0) begin n_fail++; $display("FAIL rstw_release: READY=%0b CTRL=%0b DONE=%0b required 1/1/0", INSTR_READY, CTRL, DONE); end
    tick();
    n_checks++; if (wr_cnt - w0 !== 0 || done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rstw_abandoned: writes=%0d dones=%0d required 0/0", wr_cnt - w0, done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_add();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_reset_in_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
